// File: rtl/gshare_btb_predictor.sv
// gshare direction predictor with tagged BTB, init sweep and mispredict stats.
// Ports: clk_i/reset_ni; pred_* fetch request/response; upd_* commit training;
// ready_o marks sweep done; mispredict_cnt_o saturating mispredict count.
module gshare_btb_predictor #(
    parameter int         HISTORY_SIZE = 4,
    parameter int         PC_WIDTH     = 32,
    parameter int         TAG_WIDTH    = 8,
    parameter logic [1:0] INIT_CTR     = 2'b01,
    parameter int         CNT_WIDTH    = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    pred_req_i,
    input  logic [PC_WIDTH-1:0]     pred_pc_i,
    output logic                    pred_valid_o,
    output logic                    pred_taken_o,
    output logic [PC_WIDTH-1:0]     pred_target_o,
    output logic [HISTORY_SIZE-1:0] pred_ghist_o,
    input  logic                    upd_valid_i,
    input  logic [PC_WIDTH-1:0]     upd_pc_i,
    input  logic [HISTORY_SIZE-1:0] upd_ghist_i,
    input  logic                    upd_taken_i,
    input  logic [PC_WIDTH-1:0]     upd_target_i,
    input  logic                    upd_mispredict_i,
    output logic                    ready_o,
    output logic [CNT_WIDTH-1:0]    mispredict_cnt_o
);

    localparam int ENTRIES = 1 << HISTORY_SIZE;
    localparam int TAG_LO  = HISTORY_SIZE + 2;
    localparam int TAG_HI  = TAG_LO + TAG_WIDTH - 1;

    localparam logic [HISTORY_SIZE-1:0] PTR_ONE  = HISTORY_SIZE'(1);
    localparam logic [HISTORY_SIZE-1:0] PTR_LAST = '1;
    localparam logic [PC_WIDTH-1:0]     PC_FOUR  = PC_WIDTH'(4);
    localparam logic [CNT_WIDTH-1:0]    CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [HISTORY_SIZE-1:0] r_ptr;
    logic                    w_sweep;
    logic                    w_ready;

    logic [1:0]              r_pht     [ENTRIES];
    logic                    r_btb_v   [ENTRIES];
    logic [TAG_WIDTH-1:0]    r_btb_tag [ENTRIES];
    logic [PC_WIDTH-1:0]     r_btb_tgt [ENTRIES];

    logic [HISTORY_SIZE-1:0] r_ghist;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic                    r_pvalid;
    logic                    r_ptaken;
    logic [PC_WIDTH-1:0]     r_ptarget;
    logic [HISTORY_SIZE-1:0] r_pghist;

    logic [HISTORY_SIZE-1:0] w_pbidx;
    logic [HISTORY_SIZE-1:0] w_ppidx;
    logic [TAG_WIDTH-1:0]    w_ptag;
    logic                    w_hit;
    logic                    w_ptaken;
    logic [PC_WIDTH-1:0]     w_ptarget;
    logic                    w_do_pred;

    logic [HISTORY_SIZE-1:0] w_ubidx;
    logic [HISTORY_SIZE-1:0] w_upidx;
    logic [TAG_WIDTH-1:0]    w_utag;
    logic [1:0]              w_uctr;
    logic [1:0]              w_uctr_nxt;
    logic                    w_do_upd;

    logic                    w_unused;

    // FSM: INIT sweeps every table entry once, READY is terminal.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= ST_INIT;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_sweep) begin
                r_ptr <= r_ptr + PTR_ONE;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sweep     = 1'b0;
        w_ready     = 1'b0;
        unique case (r_state)
            ST_INIT: begin
                w_sweep = 1'b1;
                if (r_ptr == PTR_LAST) begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                w_ready = 1'b1;
            end
        endcase
    end

    assign w_do_pred = w_ready && pred_req_i;
    assign w_do_upd  = w_ready && upd_valid_i;

    // Prediction lookup (reads pre-update table and history state).
    assign w_pbidx   = pred_pc_i[HISTORY_SIZE+1:2];
    assign w_ptag    = pred_pc_i[TAG_HI:TAG_LO];
    assign w_ppidx   = w_pbidx ^ r_ghist;
    assign w_hit     = r_btb_v[w_pbidx] && (r_btb_tag[w_pbidx] == w_ptag);
    assign w_ptaken  = r_pht[w_ppidx][1] && w_hit;
    assign w_ptarget = w_ptaken ? r_btb_tgt[w_pbidx] : pred_pc_i + PC_FOUR;

    // Training index uses the history snapshot the prediction was made with.
    assign w_ubidx = upd_pc_i[HISTORY_SIZE+1:2];
    assign w_utag  = upd_pc_i[TAG_HI:TAG_LO];
    assign w_upidx = w_ubidx ^ upd_ghist_i;
    assign w_uctr  = r_pht[w_upidx];

    always_comb begin
        w_uctr_nxt = w_uctr;
        if (upd_taken_i) begin
            if (w_uctr != 2'b11) begin
                w_uctr_nxt = w_uctr + 2'b01;
            end
        end else if (w_uctr != 2'b00) begin
            w_uctr_nxt = w_uctr - 2'b01;
        end
    end

    // Tables carry no reset; the sweep initialises them instead.
    always_ff @(posedge clk_i) begin
        if (w_sweep) begin
            r_pht[r_ptr]   <= INIT_CTR;
            r_btb_v[r_ptr] <= 1'b0;
        end else if (w_do_upd) begin
            r_pht[w_upidx] <= w_uctr_nxt;
            if (upd_taken_i) begin
                r_btb_v[w_ubidx]   <= 1'b1;
                r_btb_tag[w_ubidx] <= w_utag;
                r_btb_tgt[w_ubidx] <= upd_target_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_ghist   <= '0;
            r_cnt     <= '0;
            r_pvalid  <= 1'b0;
            r_ptaken  <= 1'b0;
            r_ptarget <= '0;
            r_pghist  <= '0;
        end else begin
            r_pvalid <= w_do_pred;
            if (w_do_pred) begin
                r_ptaken  <= w_ptaken;
                r_ptarget <= w_ptarget;
                r_pghist  <= r_ghist;
            end
            if (w_do_upd) begin
                r_ghist <= {r_ghist[HISTORY_SIZE-2:0], upd_taken_i};
                if (upd_mispredict_i && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
            end
        end
    end

    assign pred_valid_o     = r_pvalid;
    assign pred_taken_o     = r_ptaken;
    assign pred_target_o    = r_ptarget;
    assign pred_ghist_o     = r_pghist;
    assign ready_o          = w_ready;
    assign mispredict_cnt_o = r_cnt;

    // Alignment and upper PC bits do not take part in indexing or tagging.
    assign w_unused = ^{pred_pc_i, upd_pc_i};

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Testbench for gshare_btb_predictor: directed vector table, randomized
// traffic against a behavioural model, and reset / init-sweep sequences.
module tb_gshare_btb_predictor;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        pred_req_i;
    logic [31:0] pred_pc_i;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic [3:0]  upd_ghist_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic        upd_mispredict_i;

    logic        pv, pt, rdy;
    logic [31:0] ptg;
    logic [3:0]  pgh;
    logic [15:0] cnt;

    logic        pv2, pt2, rdy2;
    logic [31:0] ptg2;
    logic [3:0]  pgh2;
    logic [1:0]  cnt2;

    int nvec = 0;
    int nerr = 0;

    always #5 clk_i = ~clk_i;

    gshare_btb_predictor dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .pred_req_i(pred_req_i), .pred_pc_i(pred_pc_i),
        .pred_valid_o(pv), .pred_taken_o(pt),
        .pred_target_o(ptg), .pred_ghist_o(pgh),
        .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i),
        .upd_ghist_i(upd_ghist_i), .upd_taken_i(upd_taken_i),
        .upd_target_i(upd_target_i),
        .upd_mispredict_i(upd_mispredict_i),
        .ready_o(rdy), .mispredict_cnt_o(cnt)
    );

    gshare_btb_predictor #(.CNT_WIDTH(2)) dut2 (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .pred_req_i(pred_req_i), .pred_pc_i(pred_pc_i),
        .pred_valid_o(pv2), .pred_taken_o(pt2),
        .pred_target_o(ptg2), .pred_ghist_o(pgh2),
        .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i),
        .upd_ghist_i(upd_ghist_i), .upd_taken_i(upd_taken_i),
        .upd_target_i(upd_target_i),
        .upd_mispredict_i(upd_mispredict_i),
        .ready_o(rdy2), .mispredict_cnt_o(cnt2)
    );

    // Behavioural model state
    int          m_pht  [16];
    bit          m_bv   [16];
    int          m_btag [16];
    logic [31:0] m_btgt [16];
    int          m_gh;
    int          m_cnt;
    bit          e_valid;
    bit          e_taken;
    logic [31:0] e_tgt;
    int          e_gh;

    typedef struct {
        bit          req;
        logic [31:0] pc;
        bit          upd;
        logic [31:0] upc;
        logic [3:0]  ugh;
        bit          utk;
        logic [31:0] utgt;
        bit          umis;
        bit          ev;
        bit          et;
        logic [31:0] etg;
        logic [3:0]  egh;
        int          ecnt;
        int          ecnt2;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_pht[i] = 1;
            m_bv[i]  = 1'b0;
        end
        m_gh    = 0;
        m_cnt   = 0;
        e_taken = 1'b0;
        e_tgt   = 32'h0;
        e_gh    = 0;
        e_valid = 1'b0;
    endtask

    task automatic idle_inputs();
        pred_req_i       = 1'b0;
        pred_pc_i        = '0;
        upd_valid_i      = 1'b0;
        upd_pc_i         = '0;
        upd_ghist_i      = '0;
        upd_taken_i      = 1'b0;
        upd_target_i     = '0;
        upd_mispredict_i = 1'b0;
    endtask

    // One READY cycle: drive, predict with the model, train it, compare.
    task automatic apply(input bit req, input logic [31:0] pc,
                         input bit upd, input logic [31:0] upc,
                         input logic [3:0] ugh, input bit utk,
                         input logic [31:0] utgt, input bit umis);
        int bi, pi, tg;
        pred_req_i       = req;
        pred_pc_i        = pc;
        upd_valid_i      = upd;
        upd_pc_i         = upc;
        upd_ghist_i      = ugh;
        upd_taken_i      = utk;
        upd_target_i     = utgt;
        upd_mispredict_i = umis;
        e_valid = req;
        if (req) begin
            bi = int'((pc >> 2) % 16);
            tg = int'((pc >> 6) % 256);
            pi = bi ^ m_gh;
            e_taken = (m_pht[pi] >= 2) && m_bv[bi] && (m_btag[bi] == tg);
            e_tgt   = e_taken ? m_btgt[bi] : pc + 32'd4;
            e_gh    = m_gh;
        end
        if (upd) begin
            bi = int'((upc >> 2) % 16);
            tg = int'((upc >> 6) % 256);
            pi = bi ^ int'(ugh);
            if (utk) begin
                if (m_pht[pi] < 3) m_pht[pi]++;
                m_bv[bi]   = 1'b1;
                m_btag[bi] = tg;
                m_btgt[bi] = utgt;
            end else if (m_pht[pi] > 0) begin
                m_pht[pi]--;
            end
            m_gh = (m_gh * 2 + int'(utk)) % 16;
            if (umis) m_cnt++;
        end
        @(posedge clk_i);
        #1;
        chk("valid", 64'(pv), 64'(e_valid));
        chk("taken", 64'(pt), 64'(e_taken));
        chk("target", 64'(ptg), 64'(e_tgt));
        chk("ghist", 64'(pgh), 64'(e_gh));
        chk("cnt", 64'(cnt), 64'((m_cnt > 65535) ? 65535 : m_cnt));
        chk("cnt2", 64'(cnt2), 64'((m_cnt > 3) ? 3 : m_cnt));
        chk("taken2", 64'(pt2), 64'(e_taken));
        chk("ready", 64'(rdy), 64'd1);
    endtask

    initial begin
        tbl[0]  = '{1, 32'h100, 0, 0, 0, 0, 0, 0,
                    1, 0, 32'h104, 4'h0, 0, 0};
        tbl[1]  = '{0, 0, 1, 32'h100, 4'h0, 1, 32'h200, 1,
                    0, 0, 32'h104, 4'h0, 1, 1};
        tbl[2]  = '{1, 32'h100, 1, 32'h100, 4'h0, 1, 32'h200, 0,
                    1, 0, 32'h104, 4'h1, 1, 1};
        tbl[3]  = '{1, 32'h100, 0, 0, 0, 0, 0, 0,
                    1, 0, 32'h104, 4'h3, 1, 1};
        tbl[4]  = '{0, 0, 1, 32'h100, 4'h3, 1, 32'h200, 1,
                    0, 0, 32'h104, 4'h3, 2, 2};
        tbl[5]  = '{1, 32'h100, 0, 0, 0, 0, 0, 0,
                    1, 0, 32'h104, 4'h7, 2, 2};
        tbl[6]  = '{0, 0, 1, 32'h100, 4'h7, 1, 32'h200, 0,
                    0, 0, 32'h104, 4'h7, 2, 2};
        tbl[7]  = '{0, 0, 1, 32'h100, 4'hF, 1, 32'h200, 0,
                    0, 0, 32'h104, 4'h7, 2, 2};
        tbl[8]  = '{1, 32'h100, 0, 0, 0, 0, 0, 0,
                    1, 1, 32'h200, 4'hF, 2, 2};
        tbl[9]  = '{1, 32'h140, 0, 0, 0, 0, 0, 0,
                    1, 0, 32'h144, 4'hF, 2, 2};
        tbl[10] = '{1, 32'h100, 1, 32'h100, 4'hF, 0, 0, 1,
                    1, 1, 32'h200, 4'hF, 3, 3};
        tbl[11] = '{1, 32'h100, 0, 0, 0, 0, 0, 0,
                    1, 0, 32'h104, 4'hE, 3, 3};
        tbl[12] = '{1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0,
                    1, 0, 32'h0, 4'hE, 3, 3};
        tbl[13] = '{0, 0, 1, 32'h200, 4'h0, 0, 0, 1,
                    0, 0, 32'h0, 4'hE, 4, 3};
        tbl[14] = '{0, 0, 1, 32'h300, 4'h0, 0, 0, 1,
                    0, 0, 32'h0, 4'hE, 5, 3};

        idle_inputs();
        model_reset();
        reset_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_valid", 64'(pv), 64'd0);
        chk("rst_taken", 64'(pt), 64'd0);
        chk("rst_target", 64'(ptg), 64'd0);
        chk("rst_ghist", 64'(pgh), 64'd0);
        chk("rst_cnt", 64'(cnt), 64'd0);
        chk("rst_ready", 64'(rdy), 64'd0);
        reset_ni = 1'b1;

        // Init sweep: requests and updates must be ignored.
        for (int k = 1; k <= 16; k++) begin
            if (k == 5) begin
                pred_req_i       = 1'b1;
                pred_pc_i        = 32'h100;
                upd_valid_i      = 1'b1;
                upd_pc_i         = 32'h100;
                upd_taken_i      = 1'b1;
                upd_target_i     = 32'h500;
                upd_mispredict_i = 1'b1;
            end else begin
                idle_inputs();
            end
            @(posedge clk_i);
            #1;
            chk("init_ready", 64'(rdy), 64'(k >= 16));
            if (k == 5) begin
                chk("init_valid", 64'(pv), 64'd0);
                chk("init_cnt", 64'(cnt), 64'd0);
            end
        end

        // Directed table
        for (int i = 0; i < 15; i++) begin
            apply(tbl[i].req, tbl[i].pc, tbl[i].upd, tbl[i].upc,
                  tbl[i].ugh, tbl[i].utk, tbl[i].utgt, tbl[i].umis);
            chk($sformatf("tbl%0d_valid", i), 64'(pv), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d_taken", i), 64'(pt), 64'(tbl[i].et));
            chk($sformatf("tbl%0d_target", i), 64'(ptg), 64'(tbl[i].etg));
            chk($sformatf("tbl%0d_ghist", i), 64'(pgh), 64'(tbl[i].egh));
            chk($sformatf("tbl%0d_cnt", i), 64'(cnt), 64'(tbl[i].ecnt));
            chk($sformatf("tbl%0d_cnt2", i), 64'(cnt2), 64'(tbl[i].ecnt2));
        end

        // Randomized traffic over a small PC set so BTB hits happen.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rpc, upc, tgt;
            logic [3:0]  ugh;
            rpc = 32'h1000 | (32'($urandom_range(0, 2)) << 6)
                  | (32'($urandom_range(0, 15)) << 2);
            upc = 32'h1000 | (32'($urandom_range(0, 2)) << 6)
                  | (32'($urandom_range(0, 15)) << 2);
            tgt = $urandom & 32'hFFFF_FFFC;
            ugh = ($urandom_range(0, 1) == 1) ? 4'(m_gh)
                                              : 4'($urandom_range(0, 15));
            apply($urandom_range(0, 1) == 1, rpc,
                  $urandom_range(0, 1) == 1, upc, ugh,
                  $urandom_range(0, 1) == 1, tgt,
                  $urandom_range(0, 3) == 0);
        end

        // Reset mid-sweep restarts the sweep from entry 0.
        idle_inputs();
        reset_ni = 1'b0;
        #1;
        chk("rst2_ready", 64'(rdy), 64'd0);
        chk("rst2_valid", 64'(pv), 64'd0);
        chk("rst2_target", 64'(ptg), 64'd0);
        chk("rst2_cnt", 64'(cnt), 64'd0);
        chk("rst2_cnt2", 64'(cnt2), 64'd0);
        model_reset();
        @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk_i);
            #1;
            chk("sweep_a_ready", 64'(rdy), 64'd0);
        end
        reset_ni = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(rdy), 64'd0);
        @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk_i);
            #1;
            chk("sweep_b_ready", 64'(rdy), 64'(k >= 16));
        end
        apply(1'b1, 32'h100, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        chk("cold_taken", 64'(pt), 64'd0);
        chk("cold_target", 64'(ptg), 64'h104);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
